rv32_rf_wr_arbiter: RTL and testbench
=====================================

// Module: rv32_rf_wr_arbiter
// PURPOSE
// - Owns the single write port of the 32x32 integer register file (x0 hardwired zero).
// - Shares that port between NUM_REQ writeback sources (e.g. ALU, load unit, mul/div)
//   using round-robin arbitration with a valid/ready handshake.
// - After reset, sequences a clear pass writing zero to x1..x31, then raises init_done.
// - Sits between the writeback sources and the register file's wr_en/rd_addr/rd_data inputs.
// PARAMETERS
// - NUM_REQ         3  number of writeback requesters (2..8)
// - CLEAR_ON_RESET  1  1: run the x1..x31 zero pass after reset; 0: enter RUN directly
// PORTS
// - clk          in   1                   clock, rising edge
// - rst          in   1                   reset, synchronous, active-high
// - req_valid    in   NUM_REQ             per-source write request
// - req_addr     in   NUM_REQ*REG_ADDR_W  per-source destination reg; source i at [i*5 +: 5]
// - req_data     in   NUM_REQ*XLEN        per-source write data; source i at [i*32 +: 32]
// - req_ready    out  NUM_REQ             one-hot grant; a transfer occurs when valid&ready
// - rf_wr_en     out  1                   to register file wr_en (registered)
// - rf_rd_addr   out  REG_ADDR_W          to register file rd_addr (registered)
// - rf_rd_data   out  XLEN                to register file rd_data (registered)
// - init_done    out  1                   high once in RUN; low during reset and CLEAR
// BEHAVIOUR
// - Reset values: state=CLEAR (RUN if CLEAR_ON_RESET=0), clr_idx=1, rr_ptr=0, req_ready=0,
//   rf_wr_en=0, rf_rd_addr=0, rf_rd_data=0, init_done=0 (1 if CLEAR_ON_RESET=0).
// - FSM CLEAR:
//   - Each cycle, register wr_en=1, addr=clr_idx, data=0, then increment clr_idx.
//   - When clr_idx==31 is issued, go to RUN and set init_done=1 on the same edge.
//   - 31 clear writes in total; req_ready=0 throughout.
// - FSM RUN:
//   - req_ready is combinational: one-hot, the first valid source at or after rr_ptr, modulo NUM_REQ.
//   - All zeros when no source is valid.
// - Handshake:
//   - A source holds valid/addr/data stable until it sees ready.
//   - At most one grant per cycle; ready never asserts without valid.
// - Latency:
//   - A transfer in cycle N appears on rf_* during cycle N+1.
//   - The register file commits it at the end of cycle N+1.
//   - Throughput is 1 write per cycle.
// - rf_wr_en=1 in cycle N+1 iff there was a grant in cycle N and the granted addr!=0.
// - Grant with addr==0: the request is accepted (ready=1) but the write is dropped:
//   rf_wr_en=0, and rf_rd_addr/rf_rd_data still load the granted values.
// - No grant: rf_wr_en=0, and rf_rd_addr/rf_rd_data hold their previous values.
// - rr_ptr update: after a grant to source g, rr_ptr = (g+1) mod NUM_REQ; unchanged with no grant.
// - Same addr from two sources in one cycle: only the RR winner is granted.
//   The loser is granted later, so the last-granted value persists. No merging, no reorder buffer.
// - rst mid-operation:
//   - Any registered pending write is discarded, since rf_wr_en clears on that edge.
//   - The clear pass restarts from x1.
// STRUCTURE
// - Shared package pkg_rv32_types additions:
//   - typedef enum logic {ARB_CLEAR, ARB_RUN} rf_arb_state_e;
//   - localparam RF_LAST_IDX = 31.
//   - Use the existing XLEN and REG_ADDR_W.
// - One sub-module, rv32_rr_arbiter:
//   - Combinational round-robin one-hot grant from req_valid and rr_ptr.
//   - Also produces a binary grant index.
// - Top level holds the FSM, clr_idx, rr_ptr, the output registers, and the payload mux by grant index.
// TESTING
// - Reset then idle, CLEAR_ON_RESET=1:
//   - Writes 1..31 appear on consecutive cycles, all with data=0.
//   - init_done rises after the 31st write; req_ready stays 0 until then.
// - Single source 0, valid with addr=5 and data=32'hDEADBEEF in cycle N:
//   - ready=1 in cycle N.
//   - In N+1: rf_wr_en=1, rf_rd_addr=5, rf_rd_data=32'hDEADBEEF.
// - All three valid continuously with rr_ptr=0:
//   - Grants go 0,1,2,0,1,2 on consecutive cycles, one write per cycle, and none starve.
// - Source 1 valid with addr=0 and data=32'h1:
//   - ready=1; next cycle rf_wr_en=0.
//   - rr_ptr advances to 2.
// - Sources 0 and 2 both write addr=7 (data 32'hA, 32'hB) with rr_ptr=2:
//   - Source 2 is granted first, then source 0.
//   - x7 ends at 32'hA.
// - rst asserted for 1 cycle during RUN with a grant pending:
//   - Next cycle rf_wr_en=0, init_done=0.
//   - The clear pass restarts at addr=1.

Source files
------------

// File: rtl/rv32_rf_wr_arbiter_pkg.sv
// Shared RV32 integer types plus the register-file write arbiter additions.
//   XLEN / REG_ADDR_W : datapath and register-address widths
//   rf_arb_state_e    : arbiter FSM state (clear pass vs. normal run)
//   RF_LAST_IDX       : last register written by the post-reset clear pass
package pkg_rv32_types;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {ARB_CLEAR, ARB_RUN} rf_arb_state_e;

    localparam int RF_LAST_IDX = 31;

endpackage

// File: rtl/rv32_rf_wr_arbiter_if.sv
// Writeback request bus: NUM_REQ sources, each with valid/addr/data, and a
// one-hot ready returned by the arbiter. Source i lives in packed slot [i].
//   master : writeback source side (drives valid/addr/data, sees ready)
//   slave  : arbiter side
interface rv32_rf_wr_arbiter_if
    import pkg_rv32_types::*;
#(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0][REG_ADDR_W-1:0]  req_addr;
    logic [NUM_REQ-1:0][XLEN-1:0]        req_data;
    logic [NUM_REQ-1:0]                  req_ready;

    modport master (output req_valid, req_addr, req_data, input  req_ready);
    modport slave  (input  req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/rv32_rr_arbiter.sv
// Combinational round-robin arbiter.
//   valid   : per-source request
//   ptr     : highest-priority source this cycle
//   gnt     : one-hot grant, first valid source at or after ptr (mod NUM_REQ)
//   gnt_idx : binary index of the granted source (0 when none)
//   gnt_any : some source is granted
module rv32_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);
    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // rotate the scan so it starts at ptr and wraps past the top
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            if (!gnt_any && valid[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
            end
        end
    end
endmodule

// File: rtl/rv32_rf_wr_arbiter.sv
// Owner of the single register-file write port.
// After reset it zeroes x1..x31 (one per cycle), then arbitrates writeback
// sources round-robin. A transfer in cycle N is presented to the register
// file in cycle N+1. Writes to x0 are accepted but dropped.
//   clk, rst   : clock, synchronous active-high reset
//   wb         : writeback request bus (slave side)
//   rf_wr_en   : register file write enable (registered)
//   rf_rd_addr : register file destination address (registered)
//   rf_rd_data : register file write data (registered)
//   init_done  : high once the clear pass is complete
module rv32_rf_wr_arbiter
    import pkg_rv32_types::*;
#(
    parameter int NUM_REQ        = 3,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    rv32_rf_wr_arbiter_if.slave   wb,
    output logic                  rf_wr_en,
    output logic [REG_ADDR_W-1:0] rf_rd_addr,
    output logic [XLEN-1:0]       rf_rd_data,
    output logic                  init_done
);
    localparam int IDX_W = $clog2(NUM_REQ);

    rf_arb_state_e         state;
    logic [REG_ADDR_W-1:0] clr_idx;
    logic [IDX_W-1:0]      rr_ptr;

    logic [NUM_REQ-1:0]    gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_any;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [XLEN-1:0]       sel_data;

    rv32_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .valid   (wb.req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // grants are only visible while running; the clear pass owns the port
    assign wb.req_ready = (state == ARB_RUN) ? gnt : '0;
    assign sel_addr     = wb.req_addr[gnt_idx];
    assign sel_data     = wb.req_data[gnt_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR_ON_RESET ? ARB_CLEAR : ARB_RUN;
            clr_idx    <= REG_ADDR_W'(1);
            rr_ptr     <= '0;
            rf_wr_en   <= 1'b0;
            rf_rd_addr <= '0;
            rf_rd_data <= '0;
            init_done  <= !CLEAR_ON_RESET;
        end else begin
            case (state)
                ARB_CLEAR: begin
                    rf_wr_en   <= 1'b1;
                    rf_rd_addr <= clr_idx;
                    rf_rd_data <= '0;
                    clr_idx    <= clr_idx + 1'b1;
                    if (clr_idx == REG_ADDR_W'(RF_LAST_IDX)) begin
                        state     <= ARB_RUN;
                        init_done <= 1'b1;
                    end
                end
                ARB_RUN: begin
                    if (gnt_any) begin
                        // x0 is hardwired: accept the request, suppress the write
                        rf_wr_en   <= (sel_addr != '0);
                        rf_rd_addr <= sel_addr;
                        rf_rd_data <= sel_data;
                        rr_ptr     <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    end else begin
                        rf_wr_en <= 1'b0;
                    end
                end
                default: state <= ARB_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32_rf_wr_arbiter.sv
module tb_rv32_rf_wr_arbiter;
    import pkg_rv32_types::*;

    localparam int NREQ = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  rf_wr_en;
    logic [REG_ADDR_W-1:0] rf_rd_addr;
    logic [XLEN-1:0]       rf_rd_data;
    logic                  init_done;

    int n_chk = 0;
    int n_err = 0;

    logic [XLEN-1:0] rf_model [32];

    rv32_rf_wr_arbiter_if #(.NUM_REQ(NREQ)) wb ();

    rv32_rf_wr_arbiter #(.NUM_REQ(NREQ), .CLEAR_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb         (wb),
        .rf_wr_en   (rf_wr_en),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    // reference register file fed by the DUT's write port
    always @(posedge clk)
        if (rf_wr_en && rf_rd_addr != 0)
            rf_model[rf_rd_addr] <= rf_rd_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".wr_en"}, 32'(rf_wr_en), 32'(en));
        chk({tag, ".addr"},  32'(rf_rd_addr), 32'(a));
        chk({tag, ".data"},  rf_rd_data, d);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_model[i] = 32'hFFFF_FFFF;
        rst          = 1'b1;
        wb.req_valid = '0;
        wb.req_addr  = '0;
        wb.req_data  = '0;
        tick(); tick();

        // reset state
        chk_wr("reset", 1'b0, 5'd0, 32'h0);
        chk("reset.init_done", 32'(init_done), 32'h0);
        chk("reset.ready", 32'(wb.req_ready), 32'h0);

        // clear pass, with all sources requesting to prove ready stays low
        rst          = 1'b0;
        wb.req_valid = 3'b111;
        wb.req_addr  = {5'd3, 5'd2, 5'd1};
        for (int k = 1; k <= 31; k++) begin
            #1 chk($sformatf("clr%0d.ready", k), 32'(wb.req_ready), 32'h0);
            tick();
            chk_wr($sformatf("clr%0d", k), 1'b1, 5'(k), 32'h0);
            chk($sformatf("clr%0d.init_done", k), 32'(init_done), 32'(k == 31));
            if (k == 31) wb.req_valid = '0;
        end
        #1 chk("run.idle_ready", 32'(wb.req_ready), 32'h0);

        // single source 0 -> x5, ptr 0 -> 1
        wb.req_valid = 3'b001; wb.req_addr[0] = 5'd5; wb.req_data[0] = 32'hDEAD_BEEF;
        #1 chk("single.ready", 32'(wb.req_ready), 32'h1);
        tick(); wb.req_valid = '0;
        chk_wr("single", 1'b1, 5'd5, 32'hDEAD_BEEF);

        // source 1 writes x0: accepted, dropped; ptr 1 -> 2
        wb.req_valid = 3'b010; wb.req_addr[1] = 5'd0; wb.req_data[1] = 32'h1;
        #1 chk("x0.ready", 32'(wb.req_ready), 32'h2);
        tick(); wb.req_valid = '0;
        chk_wr("x0", 1'b0, 5'd0, 32'h1);

        // sources 0 and 2 both target x7, ptr 2: source 2 first
        wb.req_valid = 3'b101;
        wb.req_addr[0] = 5'd7; wb.req_data[0] = 32'hA;
        wb.req_addr[2] = 5'd7; wb.req_data[2] = 32'hB;
        #1 chk("same.ready0", 32'(wb.req_ready), 32'h4);
        tick(); wb.req_valid = 3'b001;
        chk_wr("same.first", 1'b1, 5'd7, 32'hB);
        #1 chk("same.ready1", 32'(wb.req_ready), 32'h1);
        tick(); wb.req_valid = '0;
        chk_wr("same.second", 1'b1, 5'd7, 32'hA);

        // ptr now 1; source 2 alone -> x9, ptr wraps to 0
        wb.req_valid = 3'b100; wb.req_addr[2] = 5'd9; wb.req_data[2] = 32'h99;
        #1 chk("s2.ready", 32'(wb.req_ready), 32'h4);
        tick(); wb.req_valid = '0;
        chk_wr("s2", 1'b1, 5'd9, 32'h99);

        // idle cycle: no write, payload holds
        tick();
        chk_wr("hold", 1'b0, 5'd9, 32'h99);

        // all three valid continuously from ptr 0
        wb.req_valid = 3'b111;
        wb.req_addr  = {5'd12, 5'd11, 5'd10};
        wb.req_data  = {32'h102, 32'h101, 32'h100};
        for (int k = 0; k < 6; k++) begin
            #1 chk($sformatf("rr%0d.ready", k), 32'(wb.req_ready), 32'(1 << (k % 3)));
            tick();
            chk_wr($sformatf("rr%0d", k), 1'b1, 5'(10 + k % 3), 32'h100 + 32'(k % 3));
        end
        wb.req_valid = '0;
        tick();
        chk("rr.idle_wr_en", 32'(rf_wr_en), 32'h0);

        // register file contents
        chk("rf.x1",  rf_model[1],  32'h0);
        chk("rf.x31", rf_model[31], 32'h0);
        chk("rf.x5",  rf_model[5],  32'hDEAD_BEEF);
        chk("rf.x7",  rf_model[7],  32'hA);
        chk("rf.x9",  rf_model[9],  32'h99);
        chk("rf.x10", rf_model[10], 32'h100);
        chk("rf.x12", rf_model[12], 32'h102);

        // reset during RUN with a grant pending: write discarded, clear restarts
        wb.req_valid = 3'b001; wb.req_addr[0] = 5'd20; wb.req_data[0] = 32'h55;
        rst = 1'b1;
        tick();
        rst = 1'b0; wb.req_valid = '0;
        chk("rst.wr_en", 32'(rf_wr_en), 32'h0);
        chk("rst.init_done", 32'(init_done), 32'h0);
        tick();
        chk_wr("rst.clr1", 1'b1, 5'd1, 32'h0);
        tick();
        chk_wr("rst.clr2", 1'b1, 5'd2, 32'h0);
        chk("rst.x20", rf_model[20], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
